// File: rtl/apb_lsu_if.sv
// apb_lsu_if: groups the core request/response handshake and the APB data-access
// bus of the load/store unit into one bundle.
//   req_*   : core request (valid/ready), store data right-aligned
//   rsp_*   : one-cycle response pulse with extended load data and error code
//   APB_*   : APB master signals driven by the unit and slave replies
// Modports:
//   master : the load/store unit (APB master, serves core requests)
//   slave  : the surroundings (core execute stage plus APB fabric)
interface apb_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [1:0]                req_size;
  logic                      req_unsigned;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic                      rsp_valid;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic [1:0]                rsp_err;
  logic [ADDR_WIDTH-1:0]     APB_paddr;
  logic [DATA_WIDTH-1:0]     APB_pwdata;
  logic [DATA_WIDTH-1:0]     APB_prdata;
  logic                      APB_psel;
  logic                      APB_penable;
  logic                      APB_pwrite;
  logic [DATA_WIDTH/8-1:0]   APB_pstb;
  logic                      APB_pready;
  logic                      APB_perr;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output APB_paddr, APB_pwdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
    input  APB_prdata, APB_pready, APB_perr
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  APB_paddr, APB_pwdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
    output APB_prdata, APB_pready, APB_perr
  );
endinterface

// File: rtl/apb_lsu.sv
// apb_lsu: turns single core load/store requests into APB transfers.
// Handles 32/64-bit data paths, splits boundary-crossing accesses into two
// beats (or rejects them), bounds the ACCESS wait with a timeout and encodes
// errors on rsp_err (00 ok, 01 pslverr, 10 timeout, 11 illegal/misaligned).
// Ports:
//   i_clk   : clock
//   i_rts_n : asynchronous active-low reset
//   bus     : apb_lsu_if master modport (request, response and APB signals)
module apb_lsu #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES   = 16,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic      i_clk,
  input  logic      i_rts_n,
  apb_lsu_if.master bus
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int NB2 = 2 * NB;
  localparam int DW2 = 2 * DATA_WIDTH;
  localparam int OW  = $clog2(NB);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                r_state, w_state_nx;
  logic                  r_beat, r_split;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_err;
  logic                  r_write, r_unsigned;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rd0, r_rd1;

  // Keep the low (1<<size) bytes, then sign- or zero-extend to the data width.
  function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [1:0] size,
                                                        input logic uns);
    logic [DATA_WIDTH-1:0] keep;
    logic                  sgn;
    case (size)
      2'd0:    begin keep = DATA_WIDTH'(8'hFF);         sgn = d[7];  end
      2'd1:    begin keep = DATA_WIDTH'(16'hFFFF);      sgn = d[15]; end
      2'd2:    begin keep = DATA_WIDTH'(32'hFFFF_FFFF); sgn = d[31]; end
      default: begin keep = '1;                         sgn = 1'b0;  end
    endcase
    return (d & keep) | ((sgn && !uns) ? ~keep : '0);
  endfunction

  // Decode of the incoming request (only meaningful while IDLE).
  logic [OW-1:0] w_off;
  logic [3:0]    w_len;
  logic          w_accept, w_cross, w_illegal;
  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_off     = bus.req_addr[OW-1:0];
  assign w_len     = 4'd1 << bus.req_size;
  assign w_cross   = (5'(w_off) + 5'(w_len)) > 5'(NB);
  assign w_illegal = ((bus.req_size == 2'd3) && (DATA_WIDTH == 32)) ||
                     (w_cross && (SPLIT_MISALIGNED == 0));

  // Lane placement of the latched request. Both beats come from one
  // double-width shift: the low half is beat 0, the high half is beat 1.
  logic [OW-1:0]         w_roff;
  logic [3:0]            w_rlen;
  logic [NB2-1:0]        w_mask;
  logic [DW2-1:0]        w_wide;
  logic [DATA_WIDTH-1:0] w_ld;
  logic [ADDR_WIDTH-1:0] w_paddr;
  logic                  w_timeout;
  assign w_roff    = r_addr[OW-1:0];
  assign w_rlen    = 4'd1 << r_size;
  assign w_mask    = NB2'((16'd1 << w_rlen) - 16'd1) << w_roff;
  assign w_wide    = {{DATA_WIDTH{1'b0}}, r_wdata} << {w_roff, 3'b000};
  assign w_ld      = DATA_WIDTH'({r_rd1, r_rd0} >> {w_roff, 3'b000});
  // Second beat address wraps naturally at 2^ADDR_WIDTH.
  assign w_paddr   = {r_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}} + (r_beat ? ADDR_WIDTH'(NB) : '0);
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rts_n) begin
    if (!i_rts_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx      = r_state;
    bus.req_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_rdata   = '0;
    bus.rsp_err     = 2'b00;
    bus.APB_psel    = 1'b0;
    bus.APB_penable = 1'b0;
    bus.APB_pwrite  = 1'b0;
    bus.APB_paddr   = '0;
    bus.APB_pwdata  = '0;
    bus.APB_pstb    = '0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_state_nx = w_illegal ? S_RESP : S_SETUP;
      end
      S_SETUP, S_ACCESS: begin
        bus.APB_psel    = 1'b1;
        bus.APB_penable = (r_state == S_ACCESS);
        bus.APB_pwrite  = r_write;
        bus.APB_paddr   = w_paddr;
        if (r_write) begin
          bus.APB_pwdata = r_beat ? w_wide[DW2-1:DATA_WIDTH] : w_wide[DATA_WIDTH-1:0];
          bus.APB_pstb   = r_beat ? w_mask[NB2-1:NB] : w_mask[NB-1:0];
        end else begin
          bus.APB_pstb   = '1;
        end
        if (r_state == S_SETUP) begin
          w_state_nx = S_ACCESS;
        end else if (bus.APB_pready) begin
          w_state_nx = (!bus.APB_perr && r_split && !r_beat) ? S_SETUP : S_RESP;
        end else if (w_timeout) begin
          w_state_nx = S_RESP;
        end
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = r_err;
        bus.rsp_rdata = (r_err == 2'b00 && !r_write) ? extend_load(w_ld, r_size, r_unsigned) : '0;
        w_state_nx    = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Control: beat index, split flag, ACCESS wait counter, error code.
  always_ff @(posedge i_clk or negedge i_rts_n) begin
    if (!i_rts_n) begin
      r_beat  <= 1'b0;
      r_split <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_beat  <= 1'b0;
          r_split <= w_cross;
          r_cnt   <= '0;
          r_err   <= w_illegal ? 2'b11 : 2'b00;
        end
        S_SETUP: r_cnt <= '0;
        S_ACCESS: begin
          if (bus.APB_pready) begin
            if (bus.APB_perr)           r_err  <= 2'b01;
            else if (r_split && !r_beat) r_beat <= 1'b1;
          end else if (w_timeout) begin
            r_err <= 2'b10;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Request fields and read-beat slots; outputs are gated by state, so these
  // need no reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_write    <= bus.req_write;
      r_size     <= bus.req_size;
      r_unsigned <= bus.req_unsigned;
      r_addr     <= bus.req_addr;
      r_wdata    <= bus.req_wdata;
      r_rd1      <= '0;
    end
    if (r_state == S_ACCESS && bus.APB_pready && !bus.APB_perr) begin
      if (r_beat) r_rd1 <= bus.APB_prdata;
      else        r_rd0 <= bus.APB_prdata;
    end
  end
endmodule

// File: tb/tb_apb_lsu.sv
// tb_apb_lsu: directed bench for apb_lsu with a response scoreboard.
// Three instances: u0 (32-bit, TIMEOUT_CYCLES=4, split on), u1 (32-bit, split
// off), u2 (64-bit). One shared stimulus set; 'sel' routes req_valid and the
// observed outputs to one instance at a time.
module tb_apb_lsu;
  logic        clk = 1'b0;
  logic        rts_n;
  int          sel;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, prdata;
  logic        pready, perr;

  logic        obs_req_ready, obs_rsp_valid, obs_psel, obs_penable, obs_pwrite;
  logic [1:0]  obs_rsp_err;
  logic [63:0] obs_rsp_rdata, obs_pwdata;
  logic [31:0] obs_paddr;
  logic [7:0]  obs_pstb;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [63:0] rdata; logic [1:0] err; int lat; } exp_t;
  exp_t sbq[$];

  int          n_setup, n_access;
  logic [31:0] b_paddr[2];
  logic [63:0] b_pwdata[2];
  logic [7:0]  b_pstb[2];
  logic        b_pwrite[2];

  always #5 clk = ~clk;

  apb_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
  apb_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();
  apb_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) if2 ();

  apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4), .SPLIT_MISALIGNED(1))
    u0 (.i_clk(clk), .i_rts_n(rts_n), .bus(if0));
  apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .SPLIT_MISALIGNED(0))
    u1 (.i_clk(clk), .i_rts_n(rts_n), .bus(if1));
  apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(16), .SPLIT_MISALIGNED(1))
    u2 (.i_clk(clk), .i_rts_n(rts_n), .bus(if2));

  assign if0.req_valid = req_valid && (sel == 0);
  assign if1.req_valid = req_valid && (sel == 1);
  assign if2.req_valid = req_valid && (sel == 2);
  assign if0.req_write = req_write;   assign if1.req_write = req_write;   assign if2.req_write = req_write;
  assign if0.req_size = req_size;     assign if1.req_size = req_size;     assign if2.req_size = req_size;
  assign if0.req_unsigned = req_unsigned; assign if1.req_unsigned = req_unsigned; assign if2.req_unsigned = req_unsigned;
  assign if0.req_addr = req_addr;     assign if1.req_addr = req_addr;     assign if2.req_addr = req_addr;
  assign if0.req_wdata = req_wdata[31:0]; assign if1.req_wdata = req_wdata[31:0]; assign if2.req_wdata = req_wdata;
  assign if0.APB_prdata = prdata[31:0];   assign if1.APB_prdata = prdata[31:0];   assign if2.APB_prdata = prdata;
  assign if0.APB_pready = pready;     assign if1.APB_pready = pready;     assign if2.APB_pready = pready;
  assign if0.APB_perr = perr;         assign if1.APB_perr = perr;         assign if2.APB_perr = perr;

  always_comb begin
    obs_req_ready = if0.req_ready;     obs_rsp_valid = if0.rsp_valid;
    obs_rsp_rdata = 64'(if0.rsp_rdata); obs_rsp_err = if0.rsp_err;
    obs_psel = if0.APB_psel;           obs_penable = if0.APB_penable;
    obs_pwrite = if0.APB_pwrite;       obs_paddr = if0.APB_paddr;
    obs_pwdata = 64'(if0.APB_pwdata);  obs_pstb = 8'(if0.APB_pstb);
    if (sel == 1) begin
      obs_req_ready = if1.req_ready;     obs_rsp_valid = if1.rsp_valid;
      obs_rsp_rdata = 64'(if1.rsp_rdata); obs_rsp_err = if1.rsp_err;
      obs_psel = if1.APB_psel;           obs_penable = if1.APB_penable;
      obs_pwrite = if1.APB_pwrite;       obs_paddr = if1.APB_paddr;
      obs_pwdata = 64'(if1.APB_pwdata);  obs_pstb = 8'(if1.APB_pstb);
    end else if (sel == 2) begin
      obs_req_ready = if2.req_ready;     obs_rsp_valid = if2.rsp_valid;
      obs_rsp_rdata = if2.rsp_rdata;     obs_rsp_err = if2.rsp_err;
      obs_psel = if2.APB_psel;           obs_penable = if2.APB_penable;
      obs_pwrite = if2.APB_pwrite;       obs_paddr = if2.APB_paddr;
      obs_pwdata = if2.APB_pwdata;       obs_pstb = if2.APB_pstb;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request on instance s, act as the APB slave, and check the
  // response against the scoreboard entry pushed here. waits = low-pready
  // ACCESS cycles per beat; hold = cycles req_valid stays high while busy.
  task automatic txn(input int s, input logic wr, input logic [1:0] sz, input logic un,
                     input logic [31:0] addr, input logic [63:0] wd,
                     input logic [63:0] rd0, input logic [63:0] rd1,
                     input int waits, input logic perr0, input int hold,
                     input logic [63:0] exp_rd, input logic [1:0] exp_err, input int exp_lat);
    exp_t e;
    bit   done;
    int   acc;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sbq.push_back(e);
    n_setup = 0; n_access = 0; acc = 0; done = 0;
    @(negedge clk);
    sel = s; req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
    req_addr = addr; req_wdata = wd;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      if (cyc > hold) req_valid = 1'b0;
      pready = 1'b0; perr = 1'b0; prdata = '0;
      if (cyc == 1 && exp_lat > 1) chk("busy_req_ready", 64'(obs_req_ready), 64'd0);
      if (obs_psel && !obs_penable) begin
        if (n_setup < 2) begin
          b_paddr[n_setup] = obs_paddr;  b_pwdata[n_setup] = obs_pwdata;
          b_pstb[n_setup] = obs_pstb;    b_pwrite[n_setup] = obs_pwrite;
        end
        n_setup++; acc = 0;
        pready = 1'b1;  // must be ignored during SETUP
      end else if (obs_psel && obs_penable) begin
        n_access++; acc++;
        if (n_setup inside {1, 2}) begin
          chk("stable_paddr", 64'(obs_paddr), 64'(b_paddr[n_setup-1]));
          chk("stable_pwdata", obs_pwdata, b_pwdata[n_setup-1]);
          chk("stable_pstb", 64'(obs_pstb), 64'(b_pstb[n_setup-1]));
        end
        pready = (acc > waits);
        prdata = (n_setup == 2) ? rd1 : rd0;
        perr   = perr0 && (n_setup == 1);
      end
      if (obs_rsp_valid) begin
        done = 1;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $error("FAIL rsp_unexpected: got rsp_valid, expected no response pending");
        end else begin
          e = sbq.pop_front();
          chk("rsp_rdata", obs_rsp_rdata, e.rdata);
          chk("rsp_err", 64'(obs_rsp_err), 64'(e.err));
          chk("rsp_latency", 64'(cyc), 64'(e.lat));
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $error("FAIL rsp_timeout: got no rsp_valid in 60 cycles, expected one");
      void'(sbq.pop_front());
    end
    req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rsp_single_pulse", 64'(obs_rsp_valid), 64'd0);
    end
  endtask

  initial begin
    rts_n = 1'b0; sel = 0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; prdata = '0; pready = 1'b0; perr = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("reset_req_ready", 64'(obs_req_ready), 64'd1);
      chk("reset_psel", 64'({obs_psel, obs_penable, obs_rsp_valid}), 64'd0);
      chk("reset_paddr", 64'(obs_paddr), 64'd0);
      chk("reset_pstb", 64'(obs_pstb), 64'd0);
    end
    @(negedge clk); rts_n = 1'b1;

    // Store byte at 0x1003.
    txn(0, 1, 2'd0, 0, 32'h1003, 64'hAB, 0, 0, 0, 0, 0, 64'h0, 2'b00, 3);
    chk("sb_paddr", 64'(b_paddr[0]), 64'h1000);
    chk("sb_pwdata", b_pwdata[0], 64'hAB00_0000);
    chk("sb_pstb", 64'(b_pstb[0]), 64'h8);
    chk("sb_pwrite", 64'(b_pwrite[0]), 64'd1);
    chk("sb_beats", 64'(n_setup), 64'd1);

    // Half loads, signed then unsigned.
    txn(0, 0, 2'd1, 0, 32'h2002, 0, 64'h8001_1234, 0, 0, 0, 0, 64'hFFFF_8001, 2'b00, 3);
    chk("lh_pstb", 64'(b_pstb[0]), 64'hF);
    chk("lh_pwrite", 64'(b_pwrite[0]), 64'd0);
    txn(0, 0, 2'd1, 1, 32'h2002, 0, 64'h8001_1234, 0, 0, 0, 0, 64'h0000_8001, 2'b00, 3);

    // Misaligned word load, split into two beats.
    txn(0, 0, 2'd2, 0, 32'h3002, 0, 64'h4433_2211, 64'h8877_6655, 0, 0, 0, 64'h6655_4433, 2'b00, 5);
    chk("split_beats", 64'(n_setup), 64'd2);
    chk("split_paddr0", 64'(b_paddr[0]), 64'h3000);
    chk("split_paddr1", 64'(b_paddr[1]), 64'h3004);

    // Same access on the non-splitting instance is rejected without bus activity.
    txn(1, 0, 2'd2, 0, 32'h3002, 0, 0, 0, 0, 0, 0, 64'h0, 2'b11, 1);
    chk("nosplit_psel", 64'(n_setup + n_access), 64'd0);

    // Timeout with pready held low.
    txn(0, 0, 2'd2, 0, 32'h4000, 0, 64'h1234_5678, 0, 1000, 0, 0, 64'h0, 2'b10, 6);
    chk("timeout_access_cycles", 64'(n_access), 64'd4);

    // pslverr on beat 0 of a split store: beat 1 never issued.
    txn(0, 1, 2'd2, 0, 32'h5002, 64'hDDCC_BBAA, 0, 0, 0, 1, 0, 64'h0, 2'b01, 3);
    chk("perr_beats", 64'(n_setup), 64'd1);
    chk("perr_paddr", 64'(b_paddr[0]), 64'h5000);

    // Split store lanes and strobes.
    txn(0, 1, 2'd2, 0, 32'h1002, 64'hDDCC_BBAA, 0, 0, 0, 0, 0, 64'h0, 2'b00, 5);
    chk("ss_pwdata0", b_pwdata[0], 64'hBBAA_0000);
    chk("ss_pstb0", 64'(b_pstb[0]), 64'hC);
    chk("ss_paddr1", 64'(b_paddr[1]), 64'h1004);
    chk("ss_pwdata1", b_pwdata[1], 64'h0000_DDCC);
    chk("ss_pstb1", 64'(b_pstb[1]), 64'h3);

    // Wait states, signed byte at offset 1.
    txn(0, 0, 2'd0, 0, 32'h6001, 0, 64'h0000_8000, 0, 2, 0, 0, 64'hFFFF_FF80, 2'b00, 5);
    chk("wait_access_cycles", 64'(n_access), 64'd3);

    // Second-beat address wraps to 0.
    txn(0, 0, 2'd2, 0, 32'hFFFF_FFFE, 0, 64'h2211_5566, 64'h9988_4433, 0, 0, 0, 64'h4433_2211, 2'b00, 5);
    chk("wrap_paddr0", 64'(b_paddr[0]), 64'hFFFF_FFFC);
    chk("wrap_paddr1", 64'(b_paddr[1]), 64'h0);

    // Size 3 on a 32-bit path is illegal.
    txn(0, 0, 2'd3, 0, 32'h0100, 0, 0, 0, 0, 0, 0, 64'h0, 2'b11, 1);
    chk("size3_beats", 64'(n_setup), 64'd0);

    // 64-bit path: dword load, signed word in upper lanes, split dword store.
    txn(2, 0, 2'd3, 0, 32'h10, 0, 64'h8877_6655_4433_2211, 0, 0, 0, 0, 64'h8877_6655_4433_2211, 2'b00, 3);
    chk("dw_pstb", 64'(b_pstb[0]), 64'hFF);
    chk("dw_paddr", 64'(b_paddr[0]), 64'h10);
    txn(2, 0, 2'd2, 0, 32'h1C, 0, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 64'hFFFF_FFFF_8000_0000, 2'b00, 3);
    chk("w64_paddr", 64'(b_paddr[0]), 64'h18);
    txn(2, 1, 2'd3, 0, 32'h0E, 64'h0807_0605_0403_0201, 0, 0, 0, 0, 0, 64'h0, 2'b00, 5);
    chk("sd_paddr0", 64'(b_paddr[0]), 64'h08);
    chk("sd_pwdata0", b_pwdata[0], 64'h0201_0000_0000_0000);
    chk("sd_pstb0", 64'(b_pstb[0]), 64'hC0);
    chk("sd_paddr1", 64'(b_paddr[1]), 64'h10);
    chk("sd_pwdata1", b_pwdata[1], 64'h0000_0807_0605_0403);
    chk("sd_pstb1", 64'(b_pstb[1]), 64'h3F);

    // req_valid held while busy produces only one transfer.
    txn(0, 0, 2'd0, 1, 32'h8000, 0, 64'h7F, 0, 0, 0, 2, 64'h7F, 2'b00, 3);
    chk("busy_one_beat", 64'(n_setup), 64'd1);

    // Reset asserted mid-ACCESS aborts the transfer with no response.
    @(negedge clk);
    sel = 0; pready = 1'b0; perr = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h7000;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_access", 64'({obs_psel, obs_penable}), 64'h3);
    #2 rts_n = 1'b0;
    #1;
    chk("abort_psel", 64'({obs_psel, obs_penable}), 64'd0);
    chk("abort_req_ready", 64'(obs_req_ready), 64'd1);
    @(negedge clk);
    chk("abort_rsp", 64'(obs_rsp_valid), 64'd0);
    rts_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", 64'(obs_rsp_valid), 64'd0);
    end
    chk("abort_ready_after", 64'(obs_req_ready), 64'd1);
    txn(0, 1, 2'd1, 0, 32'h9002, 64'h1234, 0, 0, 0, 0, 0, 64'h0, 2'b00, 3);
    chk("post_pwdata", b_pwdata[0], 64'h1234_0000);
    chk("post_pstb", 64'(b_pstb[0]), 64'hC);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_lsu.md
Name: apb_lsu

Overview:
Parametrised load/store unit that turns single core memory requests into APB transfers. It supersedes the fixed 32-bit word/half/byte access path embedded in the microcoded core.
- Generalised to 32- or 64-bit data paths.
- Adds split handling of misaligned accesses, an access timeout, and encoded error responses.
- Sits between the core's execute stage and the APB fabric, and is the sole APB master for data accesses.

Parameters:
ADDR_WIDTH, 32, APB address width.
DATA_WIDTH, 32, APB data width; legal values are 32 and 64. NB = DATA_WIDTH/8.
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles waiting for pready (must be >=1).
SPLIT_MISALIGNED, 1, 1 = split a boundary-crossing access into two beats; 0 = reject it with an error.

Ports:
clk  in  1  clock
rts_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  unit idle; the request is accepted when req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_WIDTH=64)
req_unsigned  in  1  zero-extend load data (otherwise sign-extend)
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse; no backpressure
rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
rsp_err  out  2  00 ok, 01 pslverr, 10 timeout, 11 illegal/misaligned
APB_paddr  out  ADDR_WIDTH  NB-aligned transfer address
APB_pwdata  out  DATA_WIDTH  lane-shifted store data
APB_prdata  in  DATA_WIDTH  read data
APB_psel  out  1  select
APB_penable  out  1  enable
APB_pwrite  out  1  write
APB_pstb  out  NB  byte strobe; all ones for reads
APB_pready  in  1  ready
APB_perr  in  1  slave error

Behaviour:
- Reset (asynchronous, takes effect immediately): all outputs 0, except req_ready, which is 1. FSM goes to IDLE, timeout counter is cleared, and no response is produced for an aborted transfer.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: req_ready=1. On acceptance, latch all request fields and compute the byte offset off = addr mod NB and the access length len = 1<<size.
    - Illegal size (3 with DATA_WIDTH=32), or off+len>NB with SPLIT_MISALIGNED=0: go directly to RESP with rsp_err=11. No bus activity.
    - Otherwise go to SETUP with beat=0. A split is required when off+len>NB.
  - SETUP: psel=1, penable=0. paddr = aligned address + beat*NB. pwrite = stored req_write. Go to ACCESS.
  - ACCESS: psel=1, penable=1. The counter increments each cycle pready is low.
    - pready=1 && perr=1: rsp_err=01 → RESP. Any remaining beat is skipped.
    - pready=1 && perr=0: capture prdata into beat slot; if a split is required and beat=0, set beat=1 → SETUP, else → RESP.
    - Counter reaches TIMEOUT_CYCLES with pready still low: drop psel/penable, rsp_err=10 → RESP.
  - RESP: rsp_valid=1 for exactly one cycle → IDLE.
- No-wait-state latency: acceptance in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3. A split access adds 2 cycles.
- Store data and strobes:
  - Beat 0: pwdata = wdata << (8*off); pstb bits [off, min(off+len,NB)-1] set.
  - Beat 1: pwdata = wdata >> (8*(NB-off)); pstb bits [0, off+len-NB-1] set.
- Load data: the two beats are concatenated as {beat1, beat0} and shifted right by 8*off. The low len bytes are taken, then sign- or zero-extended to DATA_WIDTH.
- paddr, pwdata, pwrite and pstb are held stable from SETUP through the end of ACCESS. psel is never asserted in IDLE or RESP.
- Address arithmetic wraps modulo 2^ADDR_WIDTH for the second beat.
- req_valid while busy is ignored; it is not queued.
- pready sampled during SETUP is ignored.

Test Plan:
- Store byte, DATA_WIDTH=32, addr 0x1003, wdata 0xAB → paddr 0x1000, pwdata 0xAB000000, pstb 1000, pwrite 1; rsp_valid 3 cycles after acceptance, rsp_err 00.
- Load half signed at 0x2002 with prdata 0x80011234 → rsp_rdata 0xFFFF8001. The same load unsigned → 0x00008001.
- Word load at 0x3002, SPLIT_MISALIGNED=1 → beat 0 paddr 0x3000 (prdata 0x44332211), beat 1 paddr 0x3004 (prdata 0x88776655); rsp_rdata 0x66554433, rsp_valid 5 cycles after acceptance. With SPLIT_MISALIGNED=0 → no psel, rsp_err 11.
- TIMEOUT_CYCLES=4, pready held low → psel drops after 4 ACCESS cycles, rsp_err 10, rsp_rdata 0. pslverr on beat 0 of a split store → beat 1 is never issued, rsp_err 01.
- rts_n asserted mid-ACCESS → psel/penable go to 0 asynchronously, no rsp_valid. After release, req_ready=1 and the next request completes normally.
- DATA_WIDTH=64: dword load at 0x10 → pstb 0xFF, rsp_rdata = prdata. Size 3 with DATA_WIDTH=32 → rsp_err 11.
